normalizer: RTL and testbench
=============================

# normalizer

Post-add normalization and rounding stage that sits directly downstream of the adder's raw-sum datapath. Accepts an unnormalized sign/exponent/extended-mantissa triple with guard, round and sticky bits. Normalizes the value iteratively, one bit per clock, then rounds to nearest-even and packs an IEEE-754 single-precision result with infinity/NaN flags.

## Interface
Parameters: none (fixed to binary32).
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous and active-high
- data_valid_i  input  1  one-cycle start strobe; sampled only in IDLE
- sign_i  input  1  result sign
- exp_i  input  8  biased exponent of mant_i; 0 is treated as 1 (subnormal scale)
- mant_i  input  28  [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
- infinity_i  input  1  upstream infinity result
- nan_i  input  1  upstream NaN result; has priority over infinity_i
- z_o  output  32  packed result; held until next completion
- z_infinity_o  output  1  z_o is ±infinity, including overflow
- z_nan_o  output  1  z_o is NaN
- data_valid_o  output  1  one-cycle pulse when z_o and the flags are updated
- busy_o  output  1  high from the accept edge to the completion edge, inclusive

## Operation
- States: IDLE, NORM, ROUND, SPECIAL.
- IDLE: on data_valid_i, register all inputs and assert busy_o. Next state:
  - SPECIAL if nan_i or infinity_i, or if mant_i == 0.
  - NORM otherwise.
- SPECIAL, in priority order:
  - NaN: z = 0x7FC00000, z_nan_o = 1.
  - Infinity: z = {sign, 0xFF, 0}, z_infinity_o = 1.
  - Zero: z = {sign, 31'h0}.
  - Then go to IDLE.
- NORM, evaluated once per cycle:
  - If mant[27]: shift right 1 (new sticky = S | bit0), exp += 1, go to ROUND.
  - Else if mant[26] == 0 and exp > 1: shift left 1 (zero fill), exp -= 1, stay in NORM.
  - Else: go to ROUND.
- ROUND (round to nearest, ties to even):
  - inc = G & (R | S | mant[3]).
  - m24 = mant[26:3] + inc, computed with 25 bits.
  - If m24 carries out: m24 >>= 1, exp += 1.
- Packing:
  - exp ≥ 255: z = {sign, 0xFF, 0}, z_infinity_o = 1.
  - Hidden bit = 0 (subnormal; exp is necessarily 1): exp field = 0.
  - Otherwise: exp field = exp.
  - fraction = m24[22:0].
- Subnormal rounding that produces hidden = 1 yields exp field 1 naturally.
- Internal exponent width is 9 bits, so there is no wrap at 255.
- Flags are cleared on every completion that does not set them.
- data_valid_i is ignored while busy_o = 1; there is no queueing.
- Reset mid-operation aborts the operation: no data_valid_o pulse, outputs return to reset values.

## Timing
- Reset values: z_o = 0, z_infinity_o = 0, z_nan_o = 0, data_valid_o = 0, busy_o = 0, state = IDLE.
- Edge A: data_valid_i is sampled high in IDLE.
- Special path: z_o is updated at edge A+1. data_valid_o is high during the cycle after A+1. Latency 1.
- Normal path: latency 2 + n, where n is the number of left shifts (0..26).
  - NORM consumes n + 1 edges; the carry case is n = 0.
  - ROUND writes z_o and raises data_valid_o at edge A+n+2.
  - Maximum latency is 28.
- busy_o falls on the same edge that raises data_valid_o.
- A new data_valid_i may be accepted on the edge immediately after data_valid_o rises, which gives back-to-back operation.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Already normalized: sign 0, exp 0x8A, mant 0x400C0D0 → z 0x4500181A. data_valid_o 2 cycles after accept.
- Carry (1.5 + 1.5): sign 0, exp 0x7F, mant 0xC000000 → z 0x40400000, latency 2.
- Cancellation (0.5 − 0.4375): sign 0, exp 0x7E, mant 0x0800000 → z 0x3D800000. 3 shifts, latency 5, busy_o high for 5 edges.
- Ties-to-even: exp 0x7F, mant 0x400000C → z 0x3F800002. Then mant 0x4000004 → z 0x3F800000 (no increment).
- Round overflow: exp 0xFE, mant 0x7FFFFFE → z 0x7F800000, z_infinity_o = 1.
- Specials, reset and busy handling:
  - nan_i = 1 → z 0x7FC00000, z_nan_o = 1, latency 1.
  - infinity_i = 1 with sign 1 → z 0xFF800000.
  - mant 0 → z 0x00000000.
  - data_valid_i pulsed while busy → ignored.
  - rst_i asserted during NORM → no data_valid_o, all outputs 0 on the next cycle.

Source files
------------

// File: rtl/normalizer.sv
// Post-add normalize/round stage: iterative one-bit-per-clock normalization,
// round-to-nearest-even, and IEEE-754 binary32 packing with inf/NaN flags.
module normalizer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_valid_i,
  input  logic        sign_i,
  input  logic [7:0]  exp_i,
  input  logic [27:0] mant_i,
  input  logic        infinity_i,
  input  logic        nan_i,
  output logic [31:0] z_o,
  output logic        z_infinity_o,
  output logic        z_nan_o,
  output logic        data_valid_o,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_NORM    = 2'd1;
  localparam logic [1:0] ST_ROUND   = 2'd2;
  localparam logic [1:0] ST_SPECIAL = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic        sign_reg, sign_next;
  logic [8:0]  exp_reg, exp_next;
  logic [27:0] mant_reg, mant_next;
  logic        inf_reg, inf_next;
  logic        nan_reg, nan_next;
  logic [31:0] z_reg, z_next;
  logic        z_inf_reg, z_inf_next;
  logic        z_nan_reg, z_nan_next;
  logic        dv_reg, dv_next;
  logic        busy_reg, busy_next;

  // Rounding datapath; a carry out of the 24-bit significand renormalizes by one.
  logic        round_inc;
  logic [24:0] round_sum;
  logic [23:0] m24;
  logic [8:0]  exp_rnd;

  assign round_inc = mant_reg[2] & (mant_reg[1] | mant_reg[0] | mant_reg[3]);
  assign round_sum = {1'b0, mant_reg[26:3]} + {24'd0, round_inc};
  assign m24       = round_sum[24] ? round_sum[24:1] : round_sum[23:0];
  assign exp_rnd   = exp_reg + {8'd0, round_sum[24]};

  always_comb begin
    state_next = state_reg;
    sign_next  = sign_reg;
    exp_next   = exp_reg;
    mant_next  = mant_reg;
    inf_next   = inf_reg;
    nan_next   = nan_reg;
    z_next     = z_reg;
    z_inf_next = z_inf_reg;
    z_nan_next = z_nan_reg;
    dv_next    = 1'b0;
    busy_next  = busy_reg;

    case (state_reg)
      ST_IDLE: begin
        if (data_valid_i) begin
          sign_next = sign_i;
          // A zero exponent carries the same scale as exponent 1 (subnormal).
          exp_next  = (exp_i == 8'd0) ? 9'd1 : {1'b0, exp_i};
          mant_next = mant_i;
          inf_next  = infinity_i;
          nan_next  = nan_i;
          busy_next = 1'b1;
          if (nan_i || infinity_i || (mant_i == 28'd0))
            state_next = ST_SPECIAL;
          else
            state_next = ST_NORM;
        end
      end

      ST_NORM: begin
        if (mant_reg[27]) begin
          mant_next  = {1'b0, mant_reg[27:2], mant_reg[1] | mant_reg[0]};
          exp_next   = exp_reg + 9'd1;
          state_next = ST_ROUND;
        end else if (!mant_reg[26] && (exp_reg > 9'd1)) begin
          mant_next = {mant_reg[26:0], 1'b0};
          exp_next  = exp_reg - 9'd1;
        end else begin
          state_next = ST_ROUND;
        end
      end

      ST_ROUND: begin
        if (exp_rnd >= 9'd255) begin
          z_next     = {sign_reg, 8'hFF, 23'd0};
          z_inf_next = 1'b1;
        end else begin
          // A clear hidden bit means the value stayed subnormal.
          z_next     = {sign_reg, (m24[23] ? exp_rnd[7:0] : 8'd0), m24[22:0]};
          z_inf_next = 1'b0;
        end
        z_nan_next = 1'b0;
        dv_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end

      default: begin
        if (nan_reg) begin
          z_next     = 32'h7FC0_0000;
          z_nan_next = 1'b1;
          z_inf_next = 1'b0;
        end else if (inf_reg) begin
          z_next     = {sign_reg, 8'hFF, 23'd0};
          z_nan_next = 1'b0;
          z_inf_next = 1'b1;
        end else begin
          z_next     = {sign_reg, 31'd0};
          z_nan_next = 1'b0;
          z_inf_next = 1'b0;
        end
        dv_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      sign_reg  <= 1'b0;
      exp_reg   <= 9'd0;
      mant_reg  <= 28'd0;
      inf_reg   <= 1'b0;
      nan_reg   <= 1'b0;
      z_reg     <= 32'd0;
      z_inf_reg <= 1'b0;
      z_nan_reg <= 1'b0;
      dv_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sign_reg  <= sign_next;
      exp_reg   <= exp_next;
      mant_reg  <= mant_next;
      inf_reg   <= inf_next;
      nan_reg   <= nan_next;
      z_reg     <= z_next;
      z_inf_reg <= z_inf_next;
      z_nan_reg <= z_nan_next;
      dv_reg    <= dv_next;
      busy_reg  <= busy_next;
    end
  end

  assign z_o          = z_reg;
  assign z_infinity_o = z_inf_reg;
  assign z_nan_o      = z_nan_reg;
  assign data_valid_o = dv_reg;
  assign busy_o       = busy_reg;

endmodule

// File: tb/tb_normalizer.sv
// Self-checking bench for normalizer: scoreboard of expected results, one task per scenario.
module tb_normalizer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        data_valid_i = 1'b0;
  logic        sign_i = 1'b0;
  logic [7:0]  exp_i = 8'd0;
  logic [27:0] mant_i = 28'd0;
  logic        infinity_i = 1'b0;
  logic        nan_i = 1'b0;
  logic [31:0] z_o;
  logic        z_infinity_o;
  logic        z_nan_o;
  logic        data_valid_o;
  logic        busy_o;

  normalizer dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_valid_i(data_valid_i),
    .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i),
    .infinity_i(infinity_i), .nan_i(nan_i),
    .z_o(z_o), .z_infinity_o(z_infinity_o), .z_nan_o(z_nan_o),
    .data_valid_o(data_valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] z;
    logic        inf;
    logic        nan;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // Drive one request (consumes the accept edge) and push its expected result.
  task automatic start_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                          input logic inf, input logic nan,
                          input logic [31:0] ez, input logic einf, input logic enan,
                          input int elat, output logic busy_after);
    exp_t x;
    x.z = ez; x.inf = einf; x.nan = enan; x.lat = elat;
    sb_q.push_back(x);
    sign_i = s; exp_i = e; mant_i = m; infinity_i = inf; nan_i = nan;
    data_valid_i = 1'b1;
    @(posedge clk_i); #1;
    data_valid_i = 1'b0; infinity_i = 1'b0; nan_i = 1'b0;
    busy_after = busy_o;
  endtask

  // Returns edges counted until data_valid_o is seen; 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_i); #1;
      if (data_valid_o) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    total_cnt += 5;
    if (z_o !== 32'd0) $display("FAIL reset_z actual=%h required=00000000", z_o); else pass_cnt++;
    if (z_infinity_o !== 1'b0) $display("FAIL reset_inf actual=%b required=0", z_infinity_o); else pass_cnt++;
    if (z_nan_o !== 1'b0) $display("FAIL reset_nan actual=%b required=0", z_nan_o); else pass_cnt++;
    if (data_valid_o !== 1'b0) $display("FAIL reset_dv actual=%b required=0", data_valid_o); else pass_cnt++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy actual=%b required=0", busy_o); else pass_cnt++;
  endtask

  // Table-driven ops shared by the normal-path, rounding and special tests.
  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic        inf;
    logic        nan;
    logic [31:0] ez;
    logic        einf;
    logic        enan;
    int          elat;
  } vec_t;

  task automatic run_table(input vec_t v[$]);
    logic busy_after;
    int   lat;
    exp_t x;
    foreach (v[k]) begin
      start_op(v[k].s, v[k].e, v[k].m, v[k].inf, v[k].nan,
               v[k].ez, v[k].einf, v[k].enan, v[k].elat, busy_after);
      wait_done(lat);
      x = sb_q.pop_front();
      $display("op %s: z=%h inf=%b nan=%b lat=%0d", v[k].name, z_o, z_infinity_o, z_nan_o, lat);
      total_cnt += 6;
      if (busy_after !== 1'b1) $display("FAIL %s_busy_accept actual=%b required=1", v[k].name, busy_after); else pass_cnt++;
      if (lat != x.lat) $display("FAIL %s_latency actual=%0d required=%0d", v[k].name, lat, x.lat); else pass_cnt++;
      if (z_o !== x.z) $display("FAIL %s_z actual=%h required=%h", v[k].name, z_o, x.z); else pass_cnt++;
      if (z_infinity_o !== x.inf) $display("FAIL %s_inf actual=%b required=%b", v[k].name, z_infinity_o, x.inf); else pass_cnt++;
      if (z_nan_o !== x.nan) $display("FAIL %s_nan actual=%b required=%b", v[k].name, z_nan_o, x.nan); else pass_cnt++;
      if (busy_o !== 1'b0) $display("FAIL %s_busy_done actual=%b required=0", v[k].name, busy_o); else pass_cnt++;
    end
  endtask

  task automatic test_normal_path();
    vec_t v[$];
    v.push_back('{"normalized", 1'b0, 8'h8A, 28'h400C0D0, 1'b0, 1'b0, 32'h4500181A, 1'b0, 1'b0, 2});
    v.push_back('{"carry",      1'b0, 8'h7F, 28'hC000000, 1'b0, 1'b0, 32'h40400000, 1'b0, 1'b0, 2});
    v.push_back('{"cancel",     1'b0, 8'h7E, 28'h0800000, 1'b0, 1'b0, 32'h3D800000, 1'b0, 1'b0, 5});
    run_table(v);
  endtask

  task automatic test_rounding();
    vec_t v[$];
    v.push_back('{"tie_up",    1'b0, 8'h7F, 28'h400000C, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0, 2});
    v.push_back('{"tie_even",  1'b0, 8'h7F, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 2});
    v.push_back('{"overflow",  1'b0, 8'hFE, 28'h7FFFFFE, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 2});
    run_table(v);
  endtask

  task automatic test_specials();
    vec_t v[$];
    v.push_back('{"nan",      1'b0, 8'h10, 28'h4000000, 1'b1, 1'b1, 32'h7FC00000, 1'b0, 1'b1, 1});
    v.push_back('{"neg_inf",  1'b1, 8'h10, 28'h4000000, 1'b1, 1'b0, 32'hFF800000, 1'b1, 1'b0, 1});
    v.push_back('{"zero",     1'b0, 8'h7F, 28'h0000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1});
    run_table(v);
  endtask

  // Completion pulse lasts one cycle and the result is held afterwards.
  task automatic test_pulse_hold();
    logic busy_after;
    int   lat;
    exp_t x;
    start_op(1'b1, 8'h7F, 28'h4000000, 1'b0, 1'b0, 32'hBF800000, 1'b0, 1'b0, 2, busy_after);
    wait_done(lat);
    x = sb_q.pop_front();
    $display("op pulse_hold: z=%h lat=%0d", z_o, lat);
    total_cnt += 2;
    if (lat != x.lat) $display("FAIL pulse_latency actual=%0d required=%0d", lat, x.lat); else pass_cnt++;
    if (z_o !== x.z) $display("FAIL pulse_z actual=%h required=%h", z_o, x.z); else pass_cnt++;
    @(posedge clk_i); #1;
    total_cnt += 2;
    if (data_valid_o !== 1'b0) $display("FAIL pulse_width actual=%b required=0", data_valid_o); else pass_cnt++;
    if (z_o !== x.z) $display("FAIL hold_z actual=%h required=%h", z_o, x.z); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    logic busy_after;
    int   lat;
    int   extra;
    exp_t x;
    start_op(1'b0, 8'h7E, 28'h0800000, 1'b0, 1'b0, 32'h3D800000, 1'b0, 1'b0, 5, busy_after);
    // Try to launch a NaN while the first operation is still running.
    nan_i = 1'b1; data_valid_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    data_valid_i = 1'b0; nan_i = 1'b0;
    wait_done(lat);
    if (lat != 0) lat += 2;
    x = sb_q.pop_front();
    $display("op busy_ignore: z=%h nan=%b lat=%0d", z_o, z_nan_o, lat);
    total_cnt += 3;
    if (lat != x.lat) $display("FAIL busy_ign_latency actual=%0d required=%0d", lat, x.lat); else pass_cnt++;
    if (z_o !== x.z) $display("FAIL busy_ign_z actual=%h required=%h", z_o, x.z); else pass_cnt++;
    if (z_nan_o !== x.nan) $display("FAIL busy_ign_nan actual=%b required=%b", z_nan_o, x.nan); else pass_cnt++;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      if (data_valid_o) extra++;
    end
    total_cnt++;
    if (extra != 0) $display("FAIL busy_ign_extra actual=%0d required=0", extra); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic busy_after;
    int   lat;
    exp_t x;
    start_op(1'b0, 8'h7F, 28'hC000000, 1'b0, 1'b0, 32'h40400000, 1'b0, 1'b0, 2, busy_after);
    wait_done(lat);
    x = sb_q.pop_front();
    $display("op b2b_first: z=%h lat=%0d", z_o, lat);
    total_cnt += 2;
    if (lat != x.lat) $display("FAIL b2b1_latency actual=%0d required=%0d", lat, x.lat); else pass_cnt++;
    if (z_o !== x.z) $display("FAIL b2b1_z actual=%h required=%h", z_o, x.z); else pass_cnt++;
    // Second request is presented for the edge right after the completion edge.
    start_op(1'b0, 8'h8A, 28'h400C0D0, 1'b0, 1'b0, 32'h4500181A, 1'b0, 1'b0, 2, busy_after);
    wait_done(lat);
    x = sb_q.pop_front();
    $display("op b2b_second: z=%h lat=%0d", z_o, lat);
    total_cnt += 3;
    if (busy_after !== 1'b1) $display("FAIL b2b2_busy actual=%b required=1", busy_after); else pass_cnt++;
    if (lat != x.lat) $display("FAIL b2b2_latency actual=%0d required=%0d", lat, x.lat); else pass_cnt++;
    if (z_o !== x.z) $display("FAIL b2b2_z actual=%h required=%h", z_o, x.z); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    logic busy_after;
    int   extra;
    start_op(1'b0, 8'h7E, 28'h0800000, 1'b0, 1'b0, 32'h3D800000, 1'b0, 1'b0, 5, busy_after);
    void'(sb_q.pop_front());  // aborted by reset, never completes
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    $display("op reset_mid: z=%h inf=%b nan=%b dv=%b busy=%b", z_o, z_infinity_o, z_nan_o, data_valid_o, busy_o);
    total_cnt += 5;
    if (z_o !== 32'd0) $display("FAIL rst_mid_z actual=%h required=00000000", z_o); else pass_cnt++;
    if (z_infinity_o !== 1'b0) $display("FAIL rst_mid_inf actual=%b required=0", z_infinity_o); else pass_cnt++;
    if (z_nan_o !== 1'b0) $display("FAIL rst_mid_nan actual=%b required=0", z_nan_o); else pass_cnt++;
    if (data_valid_o !== 1'b0) $display("FAIL rst_mid_dv actual=%b required=0", data_valid_o); else pass_cnt++;
    if (busy_o !== 1'b0) $display("FAIL rst_mid_busy actual=%b required=0", busy_o); else pass_cnt++;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      if (data_valid_o) extra++;
    end
    total_cnt++;
    if (extra != 0) $display("FAIL rst_mid_late_dv actual=%0d required=0", extra); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_normal_path();
    test_rounding();
    test_specials();
    test_pulse_hold();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
